// File: rtl/prf_wb_arbiter_pkg.sv
// Shared constants for the physical register file writeback arbiter.
package prf_wb_arbiter_pkg;

   localparam int unsigned NUM_REQ_DEF        = 6;
   localparam int unsigned REG_ADDR_WIDTH_DEF = 6;
   localparam int unsigned REG_DATA_WIDTH_DEF = 64;
   localparam int unsigned ZERO_REG           = 0;

endpackage

// File: rtl/prf_wb_arbiter_rr_pick2.sv
// Rotating two-of-N picker: first request from the pointer, then the next one
// whose destination differs from the first pick.
module prf_wb_arbiter_rr_pick2 #(
   parameter int unsigned NUM_REQ        = 6,
   parameter int unsigned REG_ADDR_WIDTH = 6,
   parameter int unsigned PTR_W          = 3
) (
   input  logic [NUM_REQ-1:0]                req,
   input  logic [PTR_W-1:0]                  ptr,
   input  logic [NUM_REQ*REG_ADDR_WIDTH-1:0] addr,
   output logic [NUM_REQ-1:0]                gnt0,
   output logic [NUM_REQ-1:0]                gnt1,
   output logic                              found0,
   output logic                              found1
);

   localparam int unsigned AW = REG_ADDR_WIDTH;

   logic [AW-1:0] addr0;

   always_comb begin
      gnt0   = '0;
      gnt1   = '0;
      found0 = 1'b0;
      found1 = 1'b0;
      addr0  = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         int unsigned idx;
         idx = (32'(ptr) + k) % NUM_REQ;
         if (req[idx]) begin
            if (!found0) begin
               found0    = 1'b1;
               gnt0[idx] = 1'b1;
               addr0     = addr[idx*AW +: AW];
            end else if (!found1 && (addr[idx*AW +: AW] != addr0)) begin
               found1    = 1'b1;
               gnt1[idx] = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/prf_wb_arbiter.sv
// Round-robin writeback arbiter: up to NUM_REQ sources onto two registered
// regfile write ports, with zero-register writes discarded.
module prf_wb_arbiter
   import prf_wb_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ        = NUM_REQ_DEF,
   parameter int unsigned REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF,
   parameter int unsigned REG_DATA_WIDTH = REG_DATA_WIDTH_DEF
) (
   input  logic                                clk,
   input  logic                                rstn,
   input  logic [NUM_REQ-1:0]                  req_valid,
   output logic [NUM_REQ-1:0]                  req_ready,
   input  logic [NUM_REQ*REG_ADDR_WIDTH-1:0]   req_address,
   input  logic [NUM_REQ*REG_DATA_WIDTH-1:0]   req_data,
   output logic                                wr_first_valid,
   output logic [REG_ADDR_WIDTH-1:0]           wr_first_address,
   output logic [REG_DATA_WIDTH-1:0]           wr_first_data,
   output logic                                wr_second_valid,
   output logic [REG_ADDR_WIDTH-1:0]           wr_second_address,
   output logic [REG_DATA_WIDTH-1:0]           wr_second_data,
   output logic [15:0]                         conflict_cnt
);

   localparam int unsigned AW    = REG_ADDR_WIDTH;
   localparam int unsigned DW    = REG_DATA_WIDTH;
   localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [PTR_W-1:0]   rr_ptr;
   logic [NUM_REQ-1:0] zero_req;
   logic [NUM_REQ-1:0] arb_req;
   logic [NUM_REQ-1:0] gnt0;
   logic [NUM_REQ-1:0] gnt1;
   logic               found0;
   logic               found1;
   logic [PTR_W-1:0]   idx0;
   logic [PTR_W-1:0]   idx1;
   logic               conflict;

   function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] i);
      return (i == PTR_W'(NUM_REQ - 1)) ? '0 : i + PTR_W'(1);
   endfunction

   // Zero-register writes are accepted immediately and never arbitrate.
   always_comb begin
      zero_req = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         zero_req[i] = req_valid[i] && (req_address[i*AW +: AW] == AW'(ZERO_REG));
      end
      arb_req = req_valid & ~zero_req;
   end

   prf_wb_arbiter_rr_pick2 #(
      .NUM_REQ        (NUM_REQ),
      .REG_ADDR_WIDTH (AW),
      .PTR_W          (PTR_W)
   ) u_pick (
      .req    (arb_req),
      .ptr    (rr_ptr),
      .addr   (req_address),
      .gnt0   (gnt0),
      .gnt1   (gnt1),
      .found0 (found0),
      .found1 (found1)
   );

   assign req_ready = rstn ? (zero_req | gnt0 | gnt1) : '0;
   assign conflict  = |(arb_req & ~(gnt0 | gnt1));

   // One-hot grants to indices for the payload muxes.
   always_comb begin
      idx0 = '0;
      idx1 = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (gnt0[i]) idx0 = PTR_W'(i);
         if (gnt1[i]) idx1 = PTR_W'(i);
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         rr_ptr            <= '0;
         wr_first_valid    <= 1'b0;
         wr_first_address  <= '0;
         wr_first_data     <= '0;
         wr_second_valid   <= 1'b0;
         wr_second_address <= '0;
         wr_second_data    <= '0;
         conflict_cnt      <= '0;
      end else begin
         wr_first_valid    <= found0;
         wr_first_address  <= found0 ? req_address[32'(idx0)*AW +: AW] : '0;
         wr_first_data     <= found0 ? req_data[32'(idx0)*DW +: DW]    : '0;
         wr_second_valid   <= found1;
         wr_second_address <= found1 ? req_address[32'(idx1)*AW +: AW] : '0;
         wr_second_data    <= found1 ? req_data[32'(idx1)*DW +: DW]    : '0;
         if (found1) begin
            rr_ptr <= wrap_inc(idx1);
         end else if (found0) begin
            rr_ptr <= wrap_inc(idx0);
         end
         if (conflict && (conflict_cnt != 16'hFFFF)) begin
            conflict_cnt <= conflict_cnt + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_prf_wb_arbiter.sv
// Directed bench for prf_wb_arbiter with a cycle-level reference model.
module tb_prf_wb_arbiter;

   localparam int unsigned N  = 6;
   localparam int unsigned AW = 6;
   localparam int unsigned DW = 64;

   logic              clk = 1'b0;
   logic              rstn;
   logic [N-1:0]      req_valid;
   logic [N-1:0]      req_ready;
   logic [N*AW-1:0]   req_address;
   logic [N*DW-1:0]   req_data;
   logic              wr_first_valid;
   logic [AW-1:0]     wr_first_address;
   logic [DW-1:0]     wr_first_data;
   logic              wr_second_valid;
   logic [AW-1:0]     wr_second_address;
   logic [DW-1:0]     wr_second_data;
   logic [15:0]       conflict_cnt;

   always #5 clk = ~clk;

   prf_wb_arbiter #(.NUM_REQ(N), .REG_ADDR_WIDTH(AW), .REG_DATA_WIDTH(DW)) dut (
      .clk               (clk),
      .rstn              (rstn),
      .req_valid         (req_valid),
      .req_ready         (req_ready),
      .req_address       (req_address),
      .req_data          (req_data),
      .wr_first_valid    (wr_first_valid),
      .wr_first_address  (wr_first_address),
      .wr_first_data     (wr_first_data),
      .wr_second_valid   (wr_second_valid),
      .wr_second_address (wr_second_address),
      .wr_second_data    (wr_second_data),
      .conflict_cnt      (conflict_cnt)
   );

   // Requester state
   logic          tv   [N];
   logic [AW-1:0] ta   [N];
   logic [DW-1:0] td   [N];
   logic          keep [N];
   int            seq = 0;

   for (genvar g = 0; g < N; g++) begin : g_pack
      assign req_valid[g]            = tv[g];
      assign req_address[g*AW +: AW] = ta[g];
      assign req_data[g*DW +: DW]    = td[g];
   end

   // Model state
   int            m_ptr = 0;
   logic          m_fv = 1'b0, m_sv = 1'b0;
   logic [AW-1:0] m_fa = '0, m_sa = '0;
   logic [DW-1:0] m_fd = '0, m_sd = '0;
   int            m_cnt = 0;
   logic [N-1:0]  last_rdy;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic set_req(input int i, input logic [AW-1:0] a, input logic k);
      tv[i]   = 1'b1;
      ta[i]   = a;
      td[i]   = {32'hDA7A_0000 + 32'(seq), 32'(i)};
      keep[i] = k;
      seq++;
   endtask

   // Spec rules: zero-address requests always ready; among the rest, first in
   // rotated order wins, then first with a different address.
   task automatic model_pick(output logic [N-1:0] r, output int g0, output int g1);
      r  = '0;
      g0 = -1;
      g1 = -1;
      if (rstn) begin
         for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (tv[i] && ta[i] == '0) r[i] = 1'b1;
            else if (tv[i]) begin
               if (g0 < 0) g0 = i;
               else if (g1 < 0 && ta[i] != ta[g0]) g1 = i;
            end
         end
         if (g0 >= 0) r[g0] = 1'b1;
         if (g1 >= 0) r[g1] = 1'b1;
      end
   endtask

   // One clock: compare at the falling edge, advance model and requesters.
   task automatic step();
      logic [N-1:0] r;
      int g0, g1;
      bit any_conflict;
      @(negedge clk);
      model_pick(r, g0, g1);
      chk("req_ready", 64'(req_ready), 64'(r));
      chk("first_valid", 64'(wr_first_valid), 64'(m_fv));
      chk("first_address", 64'(wr_first_address), 64'(m_fa));
      chk("first_data", wr_first_data, m_fd);
      chk("second_valid", 64'(wr_second_valid), 64'(m_sv));
      chk("second_address", 64'(wr_second_address), 64'(m_sa));
      chk("second_data", wr_second_data, m_sd);
      chk("conflict_cnt", 64'(conflict_cnt), 64'(m_cnt));
      total++;
      if (wr_first_valid && wr_second_valid && wr_first_address == wr_second_address) begin
         bad++;
         $display("FAIL same_address: both ports carry %0h", wr_first_address);
      end
      last_rdy = req_ready;
      if (!rstn) begin
         m_ptr = 0; m_cnt = 0;
         m_fv = 0; m_fa = '0; m_fd = '0;
         m_sv = 0; m_sa = '0; m_sd = '0;
      end else begin
         any_conflict = 0;
         for (int i = 0; i < N; i++)
            if (tv[i] && ta[i] != '0 && !r[i]) any_conflict = 1;
         if (any_conflict && m_cnt < 65535) m_cnt++;
         m_fv = (g0 >= 0); m_fa = (g0 >= 0) ? ta[g0] : '0; m_fd = (g0 >= 0) ? td[g0] : '0;
         m_sv = (g1 >= 0); m_sa = (g1 >= 0) ? ta[g1] : '0; m_sd = (g1 >= 0) ? td[g1] : '0;
         if (g1 >= 0) m_ptr = (g1 + 1) % N;
         else if (g0 >= 0) m_ptr = (g0 + 1) % N;
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         if (r[i]) begin
            if (keep[i]) set_req(i, ta[i], 1'b1);
            else tv[i] = 1'b0;
         end
      end
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin
         tv[i] = 1'b0; ta[i] = '0; td[i] = '0; keep[i] = 1'b0;
      end
      rstn = 1'b0;

      // Reset with all six valid
      for (int i = 0; i < N; i++) set_req(i, AW'(i + 1), 1'b0);
      step();
      chk("rst_ready", 64'(last_rdy), 64'h0);
      step();
      chk("rst_ready2", 64'(last_rdy), 64'h0);
      chk("rst_first_valid", 64'(wr_first_valid), 64'h0);
      chk("rst_conflict", 64'(conflict_cnt), 64'h0);

      // Six-way contention
      rstn = 1'b1;
      step();
      chk("six_g01", 64'(last_rdy), 64'b000011);
      chk("six_out_a0", 64'(wr_first_address), 64'd1);
      chk("six_out_a1", 64'(wr_second_address), 64'd2);
      step();
      chk("six_g23", 64'(last_rdy), 64'b001100);
      step();
      chk("six_g45", 64'(last_rdy), 64'b110000);
      chk("six_out_a4", 64'(wr_first_address), 64'd5);
      chk("six_conflict", 64'(conflict_cnt), 64'd2);

      // Move pointer to 4, then fairness
      set_req(3, 6'd3, 1'b0);
      step();
      chk("single_g3", 64'(last_rdy), 64'b001000);
      set_req(0, 6'd10, 1'b1);
      set_req(5, 6'd11, 1'b1);
      set_req(3, 6'd13, 1'b0);
      step();
      chk("fair_g50", 64'(last_rdy), 64'b100001);
      chk("fair_out_a", 64'(wr_first_address), 64'd11);
      step();
      chk("fair_g35", 64'(last_rdy), 64'b101000);
      keep[0] = 1'b0;
      keep[5] = 1'b0;
      step();
      chk("fair_g05", 64'(last_rdy), 64'b100001);

      // Address collision
      set_req(1, 6'd9, 1'b0);
      set_req(2, 6'd9, 1'b0);
      set_req(4, 6'd12, 1'b0);
      step();
      chk("coll_g14", 64'(last_rdy), 64'b010010);
      chk("coll_a0", 64'(wr_first_address), 64'd9);
      chk("coll_a1", 64'(wr_second_address), 64'd12);
      step();
      chk("coll_g2", 64'(last_rdy), 64'b000100);
      chk("coll_sv", 64'(wr_second_valid), 64'd0);

      // Wrap-around at the last index
      set_req(5, 6'd20, 1'b0);
      step();
      chk("wrap_g5", 64'(last_rdy), 64'b100000);
      chk("wrap_ptr_model", 64'(m_ptr), 64'd0);

      // Zero-register discard
      set_req(0, 6'd0, 1'b0);
      set_req(2, 6'd7, 1'b0);
      set_req(3, 6'd8, 1'b0);
      step();
      chk("zero_rdy", 64'(last_rdy), 64'b001101);
      chk("zero_a0", 64'(wr_first_address), 64'd7);
      chk("zero_a1", 64'(wr_second_address), 64'd8);
      chk("zero_ptr_model", 64'(m_ptr), 64'd4);
      chk("zero_conflict", 64'(conflict_cnt), 64'd5);
      for (int i = 0; i < N; i++) set_req(i, AW'(i + 1), 1'b0);
      step();
      chk("ptr4_g45", 64'(last_rdy), 64'b110000);
      step();
      step();

      // Mid-stream reset
      set_req(1, 6'd30, 1'b0);
      set_req(2, 6'd31, 1'b0);
      step();
      chk("mid_g12", 64'(last_rdy), 64'b000110);
      set_req(3, 6'd40, 1'b0);
      set_req(4, 6'd41, 1'b0);
      rstn = 1'b0;
      step();
      chk("mid_rst_ready", 64'(last_rdy), 64'h0);
      chk("mid_rst_fv", 64'(wr_first_valid), 64'd0);
      chk("mid_rst_cnt", 64'(conflict_cnt), 64'd0);
      rstn = 1'b1;
      set_req(0, 6'd50, 1'b0);
      set_req(5, 6'd51, 1'b0);
      step();
      chk("restart_g03", 64'(last_rdy), 64'b001001);
      chk("restart_a0", 64'(wr_first_address), 64'd50);
      chk("restart_a1", 64'(wr_second_address), 64'd40);
      step();
      step();
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
